pc_unit: RTL and testbench



---
 rtl/pc_unit_pkg.sv | 18 +
 rtl/pc_unit_if.sv | 32 +++
 rtl/pc_ras.sv | 66 ++++++
 rtl/pc_unit.sv | 68 ++++++
 tb/tb_pc_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Shared defaults and next-PC source encoding for the fetch PC unit.
package pc_unit_pkg;

  localparam int          PC_XLEN        = 32;
  localparam logic [31:0] PC_RESET_VEC   = 32'h0000_3000;
  localparam int          PC_INSTR_BYTES = 4;
  localparam int          PC_RAS_DEPTH   = 4;

  // Which rule produced the next PC; also exported for debug/trace.
  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_REDIR,
    SRC_HOLD,
    SRC_RAS,
    SRC_SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the pipeline control logic and the PC unit.
interface pc_unit_if
  import pc_unit_pkg::*;
#(
  parameter int XLEN      = PC_XLEN,
  parameter int RAS_DEPTH = PC_RAS_DEPTH
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            stall_f;
  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic            call_valid;
  logic            ret_valid;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   ras_count;
  logic            ras_pred;

  modport master (
    output stall_f, redir_valid, redir_target, trap_valid, trap_target,
           call_valid, ret_valid,
    input  pc, ras_count, ras_pred
  );

  modport slave (
    input  stall_f, redir_valid, redir_target, trap_valid, trap_target,
           call_valid, ret_valid,
    output pc, ras_count, ras_pred
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_unit_pkg::*;
#(
  parameter int XLEN  = PC_XLEN,
  parameter int DEPTH = PC_RAS_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  // ptr_q always addresses the top entry; pop+push rewrites it in place.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push && pop) begin
      wr_en = 1'b1;
    end else if (push) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q + PW'(1);
      ptr_d  = ptr_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset; count gates its use.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

  assign top   = mem_q[ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with trap/redirect/stall/RAS-prediction/sequential next-PC priority.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN        = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VEC),
  parameter int              INSTR_BYTES = PC_INSTR_BYTES,
  parameter int              RAS_DEPTH   = PC_RAS_DEPTH
) (
  input logic clk,
  input logic rst_n,
  pc_unit_if.slave bus
);
  localparam int              CW         = $clog2(RAS_DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

  logic [XLEN-1:0] pc_q, pc_d, seq, ras_top;
  logic [CW-1:0]   ras_cnt;
  pc_src_e         src;
  logic            push, pop, clear;

  always_comb begin
    seq = pc_q + XLEN'(INSTR_BYTES);
    if (bus.trap_valid)                          src = SRC_TRAP;
    else if (bus.redir_valid)                    src = SRC_REDIR;
    else if (bus.stall_f)                        src = SRC_HOLD;
    else if (bus.ret_valid && ras_cnt != '0)     src = SRC_RAS;
    else                                         src = SRC_SEQ;

    case (src)
      SRC_TRAP:  pc_d = bus.trap_target & ALIGN_MASK;
      SRC_REDIR: pc_d = bus.redir_target & ALIGN_MASK;
      SRC_HOLD:  pc_d = pc_q;
      SRC_RAS:   pc_d = ras_top & ALIGN_MASK;
      default:   pc_d = seq;
    endcase

    // The stack only moves when the fetch at pc is actually accepted.
    push  = (src == SRC_RAS || src == SRC_SEQ) && bus.call_valid;
    pop   = (src == SRC_RAS);
    clear = (src == SRC_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_VEC;
    else        pc_q <= pc_d;
  end

  pc_ras #(
    .XLEN (XLEN),
    .DEPTH(RAS_DEPTH),
    .CW   (CW)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .push_data(seq),
    .top      (ras_top),
    .count    (ras_cnt)
  );

  assign bus.pc        = pc_q;
  assign bus.ras_count = ras_cnt;
  assign bus.ras_pred  = pop;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios then random traffic vs a queue-based model.
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam int          XL  = 32;
  localparam int          DEP = 4;
  localparam logic [31:0] RV  = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(XL), .RAS_DEPTH(DEP)) bus();

  pc_unit #(
    .XLEN(XL), .RESET_VEC(RV), .INSTR_BYTES(4), .RAS_DEPTH(DEP)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        pred;
    logic [31:0] pc;
    int          cnt;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];   // back = most recent return address

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Drive one cycle of requests at a negedge and predict the outcome of the next edge.
  task automatic step(string tag, bit trap, logic [31:0] tt, bit redir, logic [31:0] rt,
                      bit stall, bit call, bit ret);
    exp_t        e;
    logic [31:0] seq;
    bus.trap_valid   = trap;  bus.trap_target  = tt;
    bus.redir_valid  = redir; bus.redir_target = rt;
    bus.stall_f      = stall;
    bus.call_valid   = call;  bus.ret_valid    = ret;
    e.pred = 1'b0;
    seq    = m_pc + 32'd4;
    if (trap) begin
      m_pc = tt & 32'hFFFF_FFFC;
      m_ras.delete();
    end else if (redir) begin
      m_pc = rt & 32'hFFFF_FFFC;
    end else if (!stall) begin
      if (ret && m_ras.size() > 0) begin
        m_pc   = m_ras.pop_back();
        e.pred = 1'b1;
      end else begin
        m_pc = seq;
      end
      if (call) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEP) void'(m_ras.pop_front());
      end
    end
    e.pc  = m_pc;
    e.cnt = m_ras.size();
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(string tag);
    step(tag, 0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic redirect(string tag, logic [31:0] t);
    step(tag, 0, '0, 1, t, 0, 0, 0);
  endtask

  // Reset dropped between edges while flush/stall requests are active.
  task automatic async_reset(string tag);
    bus.trap_valid = 1'b1; bus.redir_valid = 1'b1; bus.stall_f = 1'b1;
    bus.trap_target = 32'h8000_0000; bus.redir_target = 32'h9000_0000;
    #3 rst_n = 1'b0;
    #1;
    check({tag, ".rst_pc"}, bus.pc, RV);
    check({tag, ".rst_cnt"}, 32'(bus.ras_count), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    check({tag, ".rst_hold_pc"}, bus.pc, RV);
    @(negedge clk);
    bus.trap_valid = 1'b0; bus.redir_valid = 1'b0; bus.stall_f = 1'b0;
    rst_n = 1'b1;
    m_pc  = RV;
    m_ras.delete();
  endtask

  initial begin : mon_pred
    forever begin
      @(negedge clk); #2;
      if (rst_n && exp_q.size() > 0)
        check({exp_q[0].tag, ".pred"}, 32'(bus.ras_pred), 32'(exp_q[0].pred));
    end
  end

  initial begin : mon_state
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".pc"}, bus.pc, e.pc);
        check({e.tag, ".cnt"}, 32'(bus.ras_count), 32'(e.cnt));
      end
    end
  end

  initial begin : stim
    bus.stall_f = 0; bus.redir_valid = 0; bus.redir_target = '0;
    bus.trap_valid = 0; bus.trap_target = '0; bus.call_valid = 0; bus.ret_valid = 0;
    m_pc = RV;
    #12;
    check("reset_pc", bus.pc, RV);
    check("reset_cnt", 32'(bus.ras_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) idle("freerun");

    step("stall_redir", 0, '0, 1, 32'h0000_4002, 1, 0, 0);
    for (int i = 0; i < 2; i++) step("stall", 0, '0, 0, '0, 1, 0, 0);

    redirect("to3000", 32'h0000_3000);
    step("call3000", 0, '0, 0, '0, 0, 1, 0);
    idle("gap");
    step("ret_pred", 0, '0, 0, '0, 0, 0, 1);
    step("ret_empty", 0, '0, 0, '0, 0, 0, 1);

    for (int i = 1; i <= 5; i++) begin
      redirect("to_call", 32'(i) << 8);
      step("call_fill", 0, '0, 0, '0, 0, 1, 0);
    end
    for (int i = 0; i < 5; i++) step("ret_drain", 0, '0, 0, '0, 0, 0, 1);

    step("call_a", 0, '0, 0, '0, 0, 1, 0);
    step("call_b", 0, '0, 0, '0, 0, 1, 0);
    step("trap_all", 1, 32'h8000_0180, 1, 32'h0000_5000, 0, 0, 1);

    step("call_c", 0, '0, 0, '0, 0, 1, 0);
    step("callret", 0, '0, 0, '0, 0, 1, 1);
    step("ret_c", 0, '0, 0, '0, 0, 0, 1);

    redirect("to_top", 32'hFFFF_FFFC);
    idle("wrap");
    async_reset("midop");
    idle("post_rst");

    for (int i = 0; i < 400; i++) begin
      if (i % 130 == 129) async_reset("rnd_rst");
      step("rnd",
           $urandom_range(0, 99) < 3,  $urandom,
           $urandom_range(0, 99) < 10, $urandom,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 30);
    end
    idle("final");
    @(posedge clk); #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
